// File: rtl/pll_reconfig_sequencer.sv
// Queues PLL reconfig register writes and replays them over the Avalon-MM
// management port, then starts reconfiguration and waits for a stable lock.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | accept queue writes, wait for apply
// MODE     | write addr 0 = 1 (select polling mode)
// WRITE    | replay FIFO head, pop on each completed write
// START    | write addr 2 = 0 (start reconfiguration)
// POLL     | read addr 1 (status)
// POLL_GAP | idle cycle after each status read
// LOCK     | wait for LOCK_STABLE consecutive synchronized lock cycles
// DONE     | one-cycle completion, back to IDLE
module pll_reconfig_sequencer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int LOCK_STABLE = 1024,
    parameter int TIMEOUT     = 1048575
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [5:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        apply,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  queued,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = 20;

    typedef enum logic [2:0] {
        S_IDLE, S_MODE, S_WRITE, S_START, S_POLL, S_POLL_GAP, S_LOCK, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      fifo_addr [FIFO_DEPTH];
    logic [31:0]     fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [5:0]      count_q;
    logic            lock_meta_q, lock_sync_q;
    logic [SW-1:0]   stab_q;
    logic [TW-1:0]   tmo_q;
    logic            status_q, error_q, done_empty_q;
    logic            push, pop, xfer_ok, tmo_tc, tmo_load, tmo_fire, in_wait;
    logic            unused_readdata;

    assign unused_readdata = ^mgmt_readdata[31:1];

    assign xfer_ok  = !mgmt_waitrequest;
    assign wr_ready = (state_q == S_IDLE) && (count_q != 6'(FIFO_DEPTH));
    assign push     = wr_valid && wr_ready;
    assign pop      = (state_q == S_WRITE) && xfer_ok;
    assign tmo_tc   = (tmo_q == '0);
    assign in_wait  = (state_q == S_POLL) || (state_q == S_POLL_GAP) || (state_q == S_LOCK);

    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done   = (state_q == S_DONE) || done_empty_q;
    assign error  = error_q;
    assign queued = count_q;

    always_comb begin
        state_d        = state_q;
        mgmt_address   = '0;
        mgmt_write     = 1'b0;
        mgmt_read      = 1'b0;
        mgmt_writedata = '0;
        tmo_load       = 1'b0;
        tmo_fire       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (apply && count_q != 6'd0) state_d = S_MODE;
            end
            S_MODE: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd0;
                mgmt_writedata = 32'd1;
                if (xfer_ok) state_d = S_WRITE;
            end
            S_WRITE: begin
                mgmt_write     = 1'b1;
                mgmt_address   = fifo_addr[rd_ptr_q];
                mgmt_writedata = fifo_data[rd_ptr_q];
                if (xfer_ok && count_q == 6'd1) state_d = S_START;
            end
            S_START: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd2;
                mgmt_writedata = 32'd0;
                if (xfer_ok) begin
                    state_d  = S_POLL;
                    tmo_load = 1'b1;
                end
            end
            S_POLL: begin
                // the read stays up until it completes, even once the timeout has expired
                mgmt_read    = 1'b1;
                mgmt_address = 6'd1;
                if (xfer_ok) begin
                    if (tmo_tc) begin
                        state_d  = S_DONE;
                        tmo_fire = 1'b1;
                    end else begin
                        state_d = S_POLL_GAP;
                    end
                end
            end
            S_POLL_GAP: begin
                if (tmo_tc) begin
                    state_d  = S_DONE;
                    tmo_fire = 1'b1;
                end else if (status_q) begin
                    state_d = S_LOCK;
                end else begin
                    state_d = S_POLL;
                end
            end
            S_LOCK: begin
                if (tmo_tc) begin
                    state_d  = S_DONE;
                    tmo_fire = 1'b1;
                end else if (lock_sync_q && stab_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            stab_q       <= SW'(LOCK_STABLE - 1);
            tmo_q        <= '0;
            status_q     <= 1'b0;
            error_q      <= 1'b0;
            done_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                count_q  <= count_q + 6'd1;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q  <= count_q - 6'd1;
            end
            if (state_q == S_POLL && xfer_ok) status_q <= mgmt_readdata[0];
            // stability window is a down-counter reloaded whenever lock drops
            if (state_q != S_LOCK || !lock_sync_q) stab_q <= SW'(LOCK_STABLE - 1);
            else if (stab_q != '0)                 stab_q <= stab_q - SW'(1);
            if (tmo_load)                     tmo_q <= TW'(TIMEOUT - 1);
            else if (in_wait && !tmo_tc)      tmo_q <= tmo_q - TW'(1);
            if (state_q == S_IDLE && apply)   error_q <= 1'b0;
            else if (tmo_fire)                error_q <= 1'b1;
            done_empty_q <= (state_q == S_IDLE) && apply && (count_q == 6'd0);
        end
    end

    always_ff @(posedge refclk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= wr_addr;
            fifo_data[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Randomized bench for pll_reconfig_sequencer: an Avalon slave model with
// programmable stalls and status replies, checked against a transfer-list model.
module tb_pll_reconfig_sequencer;

    localparam int DEPTH = 8;
    localparam int LS    = 16;
    localparam int TMO   = 200;

    logic        refclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        apply = 1'b0;
    logic        busy, done, error;
    logic [5:0]  queued;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = '0;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;

    pll_reconfig_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .LOCK_STABLE(LS),
        .TIMEOUT    (TMO)
    ) dut (
        .refclk          (refclk),
        .rst_n           (rst_n),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .apply           (apply),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .queued          (queued),
        .mgmt_address    (mgmt_address),
        .mgmt_write      (mgmt_write),
        .mgmt_read       (mgmt_read),
        .mgmt_writedata  (mgmt_writedata),
        .mgmt_readdata   (mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked      (pll_locked)
    );

    always #10 refclk = ~refclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Avalon slave model and bus monitor, evaluated mid-cycle
    int          stall_max = 0;
    bit          stall_rand = 1'b0;
    int          status_after = 1;
    int          rd_total = 0;
    int          rd_base = 0;
    int          stall_left = 0;
    bit          prev_stall = 1'b0;
    logic [38:0] saved = '0;
    logic [38:0] obs[$];
    int          hold_viol = 0;
    int          dual_viol = 0;

    always @(negedge refclk) begin
        logic [38:0] cur;
        logic [31:0] r;
        cur = {mgmt_read, mgmt_address, mgmt_writedata};
        if (!rst_n) begin
            prev_stall       = 1'b0;
            mgmt_waitrequest = 1'b0;
        end else begin
            if (mgmt_write && mgmt_read) dual_viol++;
            if (prev_stall && (cur !== saved || !(mgmt_write || mgmt_read))) hold_viol++;
            if (mgmt_write || mgmt_read) begin
                if (!prev_stall) stall_left = stall_rand ? int'($urandom_range(0, stall_max)) : stall_max;
                mgmt_waitrequest = (stall_left > 0);
                if (stall_left > 0) stall_left--;
                r    = $urandom();
                r[0] = (status_after > 0) && (rd_total - rd_base >= status_after - 1);
                mgmt_readdata = r;
                if (!mgmt_waitrequest) begin
                    obs.push_back(cur);
                    if (mgmt_read) rd_total++;
                end
                prev_stall = mgmt_waitrequest;
                saved      = cur;
            end else begin
                mgmt_waitrequest = 1'($urandom_range(0, 1));
                prev_stall       = 1'b0;
            end
        end
    end

    logic [37:0] mq[$];

    task automatic tick();
        @(negedge refclk);
        #1;
    endtask

    task automatic push_entry(input logic [5:0] a, input logic [31:0] d);
        chk("wr_ready", wr_ready, mq.size() < DEPTH);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        if (mq.size() < DEPTH) mq.push_back({a, d});
        tick();
        wr_valid = 1'b0;
        chk("queued", queued, mq.size());
    endtask

    task automatic run_seq(input int polls, input int smax, input bit srand,
                           input bit glitch, input bit exp_err);
        int n, cyc, c, raise_cyc, base, exp_lat, nreads;
        logic [38:0] exp_list[$];
        n = mq.size();
        stall_max    = smax;
        stall_rand   = srand;
        status_after = exp_err ? 0 : polls;
        rd_base      = rd_total;
        base         = obs.size();
        exp_list.push_back({1'b0, 6'd0, 32'd1});
        foreach (mq[i]) exp_list.push_back({1'b0, mq[i]});
        exp_list.push_back({1'b0, 6'd2, 32'd0});
        nreads = exp_err ? TMO / 2 : polls;
        for (int i = 0; i < nreads; i++) exp_list.push_back({1'b1, 6'd1, 32'd0});
        mq.delete();
        apply = 1'b1;
        tick();
        apply = 1'b0;
        cyc = 1;
        c = -1;
        raise_cyc = 0;
        chk("busy_start", busy, 1);
        while (!done && cyc < 5000) begin
            if (glitch) begin
                if (c < 0 && rd_total - rd_base == polls) c = cyc;
                if (c >= 0 && cyc == c + 3) pll_locked = 1'b0;
                if (c >= 0 && cyc == c + 4) begin
                    pll_locked = 1'b1;
                    raise_cyc  = cyc;
                end
            end
            tick();
            cyc++;
        end
        chk("done_seen", done, 1);
        if (exp_err)     exp_lat = 3 + n + TMO;
        else if (glitch) exp_lat = raise_cyc + 2 + LS;
        else             exp_lat = 3 + n + 2 * polls + LS;
        if (smax == 0) chk("latency", cyc, exp_lat);
        chk("busy_done", busy, 0);
        chk("error", error, exp_err);
        chk("queued_end", queued, 0);
        tick();
        chk("done_pulse", done, 0);
        chk("xfer_count", obs.size() - base, exp_list.size());
        foreach (exp_list[i])
            if (base + i < obs.size()) chk("xfer", obs[base + i], exp_list[i]);
        chk("hold_stable", hold_viol, 0);
        chk("one_strobe", dual_viol, 0);
        repeat (3) tick();
    endtask

    task automatic apply_empty();
        int base;
        base  = obs.size();
        apply = 1'b1;
        tick();
        apply = 1'b0;
        chk("empty_done", done, 1);
        chk("empty_error", error, 0);
        chk("empty_busy", busy, 0);
        tick();
        chk("empty_pulse", done, 0);
        chk("empty_nobus", obs.size() - base, 0);
    endtask

    initial begin
        int base, guard;
        pll_locked = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_queued", queued, 0);
        chk("rst_strobe", {mgmt_write, mgmt_read}, 0);

        push_entry(6'd4, 32'h0000_0808);
        push_entry(6'd3, 32'h0001_0000);
        push_entry(6'd5, 32'h0002_0303);
        run_seq(3, 0, 1'b0, 1'b0, 1'b0);

        push_entry(6'd4, 32'h0000_0808);
        push_entry(6'd3, 32'h0001_0000);
        push_entry(6'd5, 32'h0002_0303);
        run_seq(2, 5, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < DEPTH + 1; i++) push_entry(6'($urandom()), $urandom());
        run_seq(1, 0, 1'b0, 1'b0, 1'b0);

        push_entry(6'd7, $urandom());
        push_entry(6'd8, $urandom());
        run_seq(0, 0, 1'b0, 1'b0, 1'b1);
        apply_empty();

        for (int i = 0; i < int'($urandom_range(1, DEPTH)); i++) push_entry(6'($urandom()), $urandom());
        run_seq(2, 0, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            int nent;
            nent = $urandom_range(1, DEPTH);
            for (int i = 0; i < nent; i++) push_entry(6'($urandom()), $urandom());
            run_seq($urandom_range(1, 3), $urandom_range(0, 4), 1'b1, 1'b0, 1'b0);
        end

        for (int i = 0; i < 4; i++) push_entry(6'(10 + i), $urandom());
        stall_max  = 3;
        stall_rand = 1'b0;
        base  = obs.size();
        apply = 1'b1;
        tick();
        apply = 1'b0;
        guard = 0;
        while (obs.size() - base < 2 && guard < 200) begin
            tick();
            guard++;
        end
        chk("rst_reach_write", guard < 200, 1);
        @(posedge refclk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobe", {mgmt_write, mgmt_read}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_queued", queued, 0);
        chk("mid_rst_done", done, 0);
        mq.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", wr_ready, 1);
        chk("post_rst_queued", queued, 0);
        apply_empty();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
